// File: rtl/ram_arbiter_if.sv
// Bundle of every signal between the two requesters, the arbiter and the RAM.
// The arbiter uses the slave view; requesters and the RAM side use the master view.
interface ram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 24
);
  // requester 0
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;
  // requester 1
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;
  // RAM side
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic          ram_re;
  logic [DW-1:0] ram_rdata;
  // status
  logic          busy;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_rdata,
    output ack0, rvalid0, rdata0,
    output ack1, rvalid1, rdata1,
    output ram_addr, ram_wdata, ram_we, ram_re,
    output busy
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_rdata,
    input  ack0, rvalid0, rdata0,
    input  ack1, rvalid1, rdata1,
    input  ram_addr, ram_wdata, ram_we, ram_re,
    input  busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-port synchronous RAM.
// One command in flight at a time: IDLE picks a winner, CMD drives the RAM
// for exactly one cycle, RDWAIT counts out the read latency and captures data.
module ram_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 24,
  parameter int RD_LAT = 1     // legal 1..4
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          port_q, port_d;       // port id of the command in flight
  logic          last_q, last_d;       // last-granted port (round-robin pointer)
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    cnt_q, cnt_d;         // read latency countdown
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic          ack0, ack1;
  logic          ram_we, ram_re;
  logic          gnt_valid;
  logic          gnt;

  // Next-state, grant selection and CMD-cycle strobes
  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    gnt_valid = 1'b0;
    gnt       = 1'b0;

    case (state_q)
      IDLE: begin
        // Contention goes to the port that did not win last time
        if (bus.req0 && bus.req1) begin
          gnt_valid = 1'b1;
          gnt       = ~last_q;
        end else if (bus.req0) begin
          gnt_valid = 1'b1;
          gnt       = 1'b0;
        end else if (bus.req1) begin
          gnt_valid = 1'b1;
          gnt       = 1'b1;
        end

        if (gnt_valid) begin
          port_d  = gnt;
          last_d  = gnt;
          we_d    = gnt ? bus.we1    : bus.we0;
          addr_d  = gnt ? bus.addr1  : bus.addr0;
          wdata_d = gnt ? bus.wdata1 : bus.wdata0;
          state_d = CMD;
        end
      end

      CMD: begin
        ack0   = ~port_q;
        ack1   = port_q;
        ram_we = we_q;
        ram_re = ~we_q;
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = RDWAIT;
          cnt_d   = 3'(RD_LAT);
        end
      end

      RDWAIT: begin
        cnt_d = cnt_q - 3'd1;
        // RAM output is valid in the cycle the countdown reaches 1
        if (cnt_q == 3'd1) begin
          state_d = IDLE;
          if (port_q) begin
            rdata1_d  = bus.ram_rdata;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = bus.ram_rdata;
            rvalid0_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; pointer resets to 1 so port 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      port_q    <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= 3'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // RAM address/data are the latched command, so they hold between commands
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ram_we    = ram_we;
  assign bus.ram_re    = ram_re;
  assign bus.ack0      = ack0;
  assign bus.ack1      = ack1;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: an RD_LAT=1 instance exercised by a transaction table
// plus hand sequences, and an RD_LAT=3 instance for the long-latency read.
module tb_ram_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ram_arbiter_if #(.AW(16), .DW(24)) bus1 ();
  ram_arbiter_if #(.AW(16), .DW(24)) bus3 ();

  ram_arbiter #(.AW(16), .DW(24), .RD_LAT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  ram_arbiter #(.AW(16), .DW(24), .RD_LAT(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  // RAM models: data_out valid RD_LAT edges after the command edge
  logic [23:0] mem1 [65536];
  logic [23:0] mem3 [65536];
  logic [23:0] pipe1;
  logic [23:0] pipe3 [3];

  always @(posedge clk) begin
    if (bus1.ram_we) mem1[bus1.ram_addr] <= bus1.ram_wdata;
    if (bus1.ram_re) pipe1 <= mem1[bus1.ram_addr];
  end
  assign bus1.ram_rdata = pipe1;

  always @(posedge clk) begin
    if (bus3.ram_we) mem3[bus3.ram_addr] <= bus3.ram_wdata;
    pipe3[0] <= bus3.ram_re ? mem3[bus3.ram_addr] : 24'h0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bus3.ram_rdata = pipe3[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          port;
    bit          we;
    logic [15:0] addr;
    logic [23:0] data;
    logic [23:0] exp;
  } vec_t;

  vec_t        vecs [7];
  logic [23:0] exp_rd [2];
  int          last_exp;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [15:0] a, input logic [23:0] d);
    if (p == 0) begin
      bus1.req0 = r; bus1.we0 = w; bus1.addr0 = a; bus1.wdata0 = d;
    end else begin
      bus1.req1 = r; bus1.we1 = w; bus1.addr1 = a; bus1.wdata1 = d;
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p != 0) ? bus1.ack1 : bus1.ack0;
  endfunction

  function automatic logic rvalid_of(input int p);
    return (p != 0) ? bus1.rvalid1 : bus1.rvalid0;
  endfunction

  function automatic logic [23:0] rdata_of(input int p);
    return (p != 0) ? bus1.rdata1 : bus1.rdata0;
  endfunction

  function automatic logic [23:0] val(input logic [15:0] a);
    case (a)
      16'd1887:  return 24'h00_b031;
      16'd74:    return 24'h00_1fc3;
      16'd0:     return 24'h00_0afc;
      16'd65535: return 24'hc1_0dd3;
      default:   return 24'h0;
    endcase
  endfunction

  // Single uncontended transaction, starting in an IDLE cycle; ends in IDLE
  task automatic run_txn(input int p, input bit we, input logic [15:0] a,
                         input logic [23:0] d, input logic [23:0] exp);
    drive(p, 1'b1, we, a, d);
    tick;
    chk("txn_ack", ack_of(p), 1);
    chk("txn_other_ack", ack_of(1 - p), 0);
    chk("txn_ram_addr", bus1.ram_addr, a);
    chk("txn_ram_we", bus1.ram_we, we);
    chk("txn_ram_re", bus1.ram_re, !we);
    if (we) chk("txn_ram_wdata", bus1.ram_wdata, d);
    drive(p, 1'b0, 1'b0, 16'h0, 24'h0);
    last_exp = p;
    tick;
    if (!we) begin
      chk("txn_rvalid_early", rvalid_of(p), 0);
      chk("txn_re_drop", bus1.ram_re, 0);
      tick;
      chk("txn_rvalid", rvalid_of(p), 1);
      chk("txn_rdata", rdata_of(p), exp);
      exp_rd[p] = exp;
    end
    chk("txn_busy_idle", bus1.busy, 0);
    chk("txn_other_rvalid", rvalid_of(1 - p), 0);
    chk("txn_other_rdata", rdata_of(1 - p), exp_rd[1 - p]);
  endtask

  initial begin
    logic [15:0] alist0 [4];
    logic [15:0] alist1 [4];
    int          idx [2];
    int          p;
    logic [15:0] a;
    int          busy_cycles;

    checks   = 0;
    failures = 0;

    vecs[0] = '{port: 0, we: 1'b1, addr: 16'd1887,   data: 24'h00_b031, exp: 24'h0};
    vecs[1] = '{port: 0, we: 1'b0, addr: 16'd1887,   data: 24'h0,       exp: 24'h00_b031};
    vecs[2] = '{port: 1, we: 1'b1, addr: 16'd74,     data: 24'h00_1fc3, exp: 24'h0};
    vecs[3] = '{port: 0, we: 1'b0, addr: 16'd74,     data: 24'h0,       exp: 24'h00_1fc3};
    vecs[4] = '{port: 1, we: 1'b1, addr: 16'h8000,   data: 24'hfe_dcba, exp: 24'h0};
    vecs[5] = '{port: 1, we: 1'b0, addr: 16'h8000,   data: 24'h0,       exp: 24'hfe_dcba};
    vecs[6] = '{port: 1, we: 1'b0, addr: 16'd74,     data: 24'h0,       exp: 24'h00_1fc3};

    mem3[22453] = 24'hf0_0005;
    exp_rd[0] = 24'h0;
    exp_rd[1] = 24'h0;
    last_exp  = 1;

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, 24'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 24'h0);
    bus3.req0 = 1'b0; bus3.we0 = 1'b0; bus3.addr0 = 16'h0; bus3.wdata0 = 24'h0;
    bus3.req1 = 1'b0; bus3.we1 = 1'b0; bus3.addr1 = 16'h0; bus3.wdata1 = 24'h0;
    tick;
    tick;

    // Reset state
    chk("rst_ack", {bus1.ack0, bus1.ack1}, 0);
    chk("rst_rvalid", {bus1.rvalid0, bus1.rvalid1}, 0);
    chk("rst_rdata", {8'h0, bus1.rdata0} | {8'h0, bus1.rdata1}, 0);
    chk("rst_ram_ctl", {bus1.ram_we, bus1.ram_re, bus1.busy}, 0);
    chk("rst_ram_addr", bus1.ram_addr, 0);
    chk("rst_ram_wdata", bus1.ram_wdata, 0);
    rst_n = 1'b1;
    tick;

    // Contention straight after reset: port 0 first, port 1 two cycles later
    drive(0, 1'b1, 1'b1, 16'd0, 24'h00_0afc);
    drive(1, 1'b1, 1'b1, 16'd65535, 24'hc1_0dd3);
    tick;
    chk("cont_ack0", bus1.ack0, 1);
    chk("cont_ack1_wait", bus1.ack1, 0);
    chk("cont_addr0", bus1.ram_addr, 16'd0);
    drive(0, 1'b0, 1'b0, 16'h0, 24'h0);
    tick;
    chk("cont_gap", {bus1.ack0, bus1.ack1}, 0);
    tick;
    chk("cont_ack1", bus1.ack1, 1);
    chk("cont_addr1", bus1.ram_addr, 16'd65535);
    chk("cont_wdata1", bus1.ram_wdata, 24'hc1_0dd3);
    drive(1, 1'b0, 1'b0, 16'h0, 24'h0);
    tick;
    last_exp = 1;
    run_txn(1, 1'b0, 16'd0, 24'h0, 24'h00_0afc);
    run_txn(0, 1'b0, 16'd65535, 24'h0, 24'hc1_0dd3);

    // Table of single transactions, issued back to back
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].exp);
    end

    // Both ports requesting 4 reads each: grants must alternate
    alist0[0] = 16'd1887;  alist0[1] = 16'd74; alist0[2] = 16'd0;  alist0[3] = 16'd65535;
    alist1[0] = 16'd65535; alist1[1] = 16'd0;  alist1[2] = 16'd74; alist1[3] = 16'd1887;
    idx[0] = 0;
    idx[1] = 0;
    p = 1 - last_exp;
    drive(0, 1'b1, 1'b0, alist0[0], 24'h0);
    drive(1, 1'b1, 1'b0, alist1[0], 24'h0);
    for (int g = 0; g < 8; g++) begin
      tick;
      a = (p != 0) ? alist1[idx[1]] : alist0[idx[0]];
      chk("alt_ack", ack_of(p), 1);
      chk("alt_other_ack", ack_of(1 - p), 0);
      chk("alt_addr", bus1.ram_addr, a);
      idx[p]++;
      if (idx[p] == 4) drive(p, 1'b0, 1'b0, 16'h0, 24'h0);
      else drive(p, 1'b1, 1'b0, (p != 0) ? alist1[idx[1]] : alist0[idx[0]], 24'h0);
      tick;
      tick;
      chk("alt_rvalid", rvalid_of(p), 1);
      chk("alt_rdata", rdata_of(p), val(a));
      chk("alt_other_rvalid", rvalid_of(1 - p), 0);
      exp_rd[p] = val(a);
      last_exp = p;
      p = 1 - p;
    end
    tick;
    chk("alt_done_idle", bus1.busy, 0);

    // Reset during RDWAIT: no rvalid, outputs drop at once, pointer back to 1
    run_txn(0, 1'b0, 16'd1887, 24'h0, 24'h00_b031);
    drive(0, 1'b1, 1'b0, 16'd74, 24'h0);
    tick;
    chk("rmid_ack0", bus1.ack0, 1);
    drive(0, 1'b0, 1'b0, 16'h0, 24'h0);
    tick;
    chk("rmid_busy_before", bus1.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rmid_busy", bus1.busy, 0);
    chk("rmid_enables", {bus1.ram_we, bus1.ram_re}, 0);
    chk("rmid_rdata0", bus1.rdata0, 0);
    chk("rmid_addr", bus1.ram_addr, 0);
    tick;
    chk("rmid_no_rvalid", {bus1.rvalid0, bus1.rvalid1}, 0);
    rst_n = 1'b1;
    tick;
    chk("rmid_no_rvalid2", {bus1.rvalid0, bus1.rvalid1}, 0);
    drive(0, 1'b1, 1'b1, 16'd5, 24'h00_0005);
    drive(1, 1'b1, 1'b1, 16'd6, 24'h00_0006);
    tick;
    chk("rmid_ack0_first", bus1.ack0, 1);
    chk("rmid_ack1_wait", bus1.ack1, 0);
    drive(0, 1'b0, 1'b0, 16'h0, 24'h0);
    tick;
    tick;
    chk("rmid_ack1", bus1.ack1, 1);
    drive(1, 1'b0, 1'b0, 16'h0, 24'h0);
    tick;

    // RD_LAT=3 instance: rvalid at ack+4, busy for 4 cycles after the grant cycle
    bus3.req0 = 1'b1; bus3.we0 = 1'b0; bus3.addr0 = 16'd22453;
    busy_cycles = 0;
    tick;
    chk("lat3_ack0", bus3.ack0, 1);
    chk("lat3_re", bus3.ram_re, 1);
    bus3.req0 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (bus3.busy) busy_cycles++;
      if (c < 4) begin
        tick;
        chk("lat3_no_rvalid", bus3.rvalid0, 0);
        chk("lat3_re_low", bus3.ram_re, 0);
      end
    end
    tick;
    chk("lat3_busy_cycles", busy_cycles, 4);
    chk("lat3_rvalid", bus3.rvalid0, 1);
    chk("lat3_rdata", bus3.rdata0, 24'hf0_0005);
    chk("lat3_idle", bus3.busy, 0);
    chk("lat3_rdata1", bus3.rdata1, 0);
    tick;
    chk("lat3_rvalid_pulse", bus3.rvalid0, 0);
    chk("lat3_rdata_hold", bus3.rdata0, 24'hf0_0005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
